// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing controller.
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } state_t;

endpackage

// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing FSM: decodes the header address, waits for an empty target FIFO,
// and drives header/payload/parity load strobes. Moore outputs decode from state only.
module router_fsm_ctrl
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_packet_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy
);

    localparam int ADDR_SPAN = 1 << ADDR_W;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;

    // Padded to the full address span so an invalid address indexes a zero entry.
    logic [ADDR_SPAN-1:0] empty_pad, srst_pad;
    assign empty_pad = {{(ADDR_SPAN-NUM_PORTS){1'b0}}, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign srst_pad  = {{(ADDR_SPAN-NUM_PORTS){1'b0}}, soft_reset_2, soft_reset_1, soft_reset_0};

    logic addr_ok, sel_empty, sel_srst;
    assign addr_ok   = data_in < ADDR_W'(NUM_PORTS);
    assign sel_empty = empty_pad[addr_q];
    assign sel_srst  = srst_pad[addr_q];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            state <= state_nx;
            if (state == DECODE_ADDRESS && state_nx != DECODE_ADDRESS)
                addr_q <= data_in;
        end
    end

    always_comb begin
        state_nx = state;
        if (state != DECODE_ADDRESS && sel_srst) begin
            state_nx = DECODE_ADDRESS;
        end else begin
            unique case (state)
                DECODE_ADDRESS:
                    if (pkt_valid && addr_ok)
                        state_nx = empty_pad[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA: state_nx = LOAD_DATA;
                // Full takes precedence over the end of payload.
                LOAD_DATA:
                    if (fifo_full)       state_nx = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_nx = LOAD_PARITY;
                FIFO_FULL_STATE:
                    if (!fifo_full) state_nx = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:
                    if (parity_done)           state_nx = DECODE_ADDRESS;
                    else if (low_packet_valid) state_nx = LOAD_PARITY;
                    else                       state_nx = LOAD_DATA;
                LOAD_PARITY:        state_nx = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_nx = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY:
                    if (sel_empty) state_nx = LOAD_FIRST_DATA;
                default: state_nx = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        laf_state     = (state == LOAD_AFTER_FULL);
        full_state    = (state == FIFO_FULL_STATE);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER_FULL);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural model of the
// packet controller; outputs compared at the falling edge.
module tb_router_fsm_ctrl;

    logic       clk = 1'b0;
    logic       resetn, pkt_valid, fifo_full, parity_done, low_packet_valid;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    router_fsm_ctrl dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    // Model phases (names describe what the controller is doing, not an encoding).
    localparam int IDLE = 0, HDR = 1, PAY = 2, FULL = 3, AFTER = 4, PAR = 5, CHK = 6, WAIT = 7;
    int m_ph   = IDLE;
    int m_port = 0;

    function automatic logic [7:0] expect_out(int ph);
        // {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy}
        case (ph)
            IDLE:  return 8'b1000_0000;
            HDR:   return 8'b0100_0001;
            PAY:   return 8'b0010_0100;
            FULL:  return 8'b0000_1001;
            AFTER: return 8'b0001_0101;
            PAR:   return 8'b0000_0101;
            CHK:   return 8'b0000_0011;
            default: return 8'b0000_0001;
        endcase
    endfunction

    function automatic logic [7:0] dut_out();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};
    endfunction

    task automatic model_step();
        logic [2:0] emp, srst;
        int a;
        emp  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        srst = {soft_reset_2, soft_reset_1, soft_reset_0};
        a    = int'(data_in);
        if (!resetn) begin
            m_ph = IDLE; m_port = 0;
        end else if (m_ph != IDLE && srst[m_port]) begin
            m_ph = IDLE;
        end else begin
            case (m_ph)
                IDLE: if (pkt_valid && a < 3) begin
                    m_port = a;
                    m_ph   = emp[a] ? HDR : WAIT;
                end
                HDR:   m_ph = PAY;
                PAY:   m_ph = fifo_full ? FULL : (!pkt_valid ? PAR : PAY);
                FULL:  m_ph = fifo_full ? FULL : AFTER;
                AFTER: m_ph = parity_done ? IDLE : (low_packet_valid ? PAR : PAY);
                PAR:   m_ph = CHK;
                CHK:   m_ph = fifo_full ? FULL : IDLE;
                default: m_ph = emp[m_port] ? HDR : WAIT;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are already applied; advance one edge and compare at the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk(tag, dut_out(), expect_out(m_ph));
    endtask

    task automatic idle_inputs();
        resetn = 1; pkt_valid = 0; data_in = 0; fifo_full = 0;
        fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
        parity_done = 0; low_packet_valid = 0;
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        // 1. reset
        tick("reset0");
        tick("reset1");
        chk("reset_detect", 8'(detect_add), 8'd1);
        chk("reset_busy", 8'(busy), 8'd0);
        resetn = 1;

        // 2. clean packet to port 1
        pkt_valid = 1; data_in = 2'b01; fifo_empty_1 = 1;
        tick("hdr_accept");
        chk("lfd_next", 8'(lfd_state), 8'd1);
        for (int i = 0; i < 5; i++) tick("payload");
        chk("payload_we", 8'(write_enb_reg), 8'd1);
        pkt_valid = 0;
        tick("parity");
        tick("chk_parity");
        chk("rst_int", 8'(rst_int_reg), 8'd1);
        tick("back_idle");

        // 3. busy target port 2
        pkt_valid = 1; data_in = 2'b10; fifo_empty_2 = 0;
        for (int i = 0; i < 4; i++) tick("wait_empty");
        chk("wait_busy", 8'(busy), 8'd1);
        fifo_empty_2 = 1;
        tick("wait_release");
        chk("wait_lfd", 8'(lfd_state), 8'd1);

        // 4. full mid-payload, then resume
        tick("to_ld");
        fifo_full = 1; pkt_valid = 0;
        tick("full_wins");
        chk("full_we", 8'(write_enb_reg), 8'd0);
        fifo_full = 0; pkt_valid = 1;
        tick("laf");
        tick("laf_to_ld");
        chk("resume_ld", 8'(ld_state), 8'd1);
        resetn = 0;
        tick("reset_mid");
        chk("reset_mid_we", 8'(write_enb_reg), 8'd0);
        resetn = 1;

        // 5. soft reset only from the selected port
        idle_inputs();
        pkt_valid = 1; data_in = 2'b00; fifo_empty_0 = 0;
        tick("wait_p0");
        soft_reset_1 = 1;
        tick("srst_other");
        soft_reset_1 = 0; soft_reset_0 = 1;
        tick("srst_sel");
        chk("srst_detect", 8'(detect_add), 8'd1);
        idle_inputs();

        // 6. invalid address dropped
        pkt_valid = 1; data_in = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick("invalid_addr");
            chk("invalid_we", 8'(write_enb_reg), 8'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            resetn           = ($urandom_range(63) != 0);
            pkt_valid        = ($urandom_range(3) != 0);
            data_in          = 2'($urandom_range(3));
            fifo_full        = ($urandom_range(3) == 0);
            fifo_empty_0     = $urandom_range(1) == 1;
            fifo_empty_1     = $urandom_range(1) == 1;
            fifo_empty_2     = $urandom_range(1) == 1;
            soft_reset_0     = ($urandom_range(15) == 0);
            soft_reset_1     = ($urandom_range(15) == 0);
            soft_reset_2     = ($urandom_range(15) == 0);
            parity_done      = ($urandom_range(3) == 0);
            low_packet_valid = ($urandom_range(2) == 0);
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
